// File: rtl/axi_sync_fifo.sv
// Single-clock FIFO for AXI channel payloads (AR/AW/W/R/B). The read side is first-word-fall-through.
// Latency: a word pushed at edge N is on r_data in the cycle after edge N.
// Backpressure: w_full rejects pushes and raises ovf_err. r_empty rejects pops and raises udf_err.
//
// Ports:
//   clk, rst_n       - clock and synchronous active-low reset
//   w_push/w_data    - write request and payload; w_full/w_afull report fill state
//   r_pop/r_data     - consume the head entry; r_data always shows the head
//   r_empty, count   - occupancy status (0..DEPTH)
//   err_clr          - clears the sticky ovf_err/udf_err flags
module axi_sync_fifo #(
  parameter int DATA_W       = 45,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1,
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_push,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_full,
  output logic              w_afull,
  input  logic              r_pop,
  output logic [DATA_W-1:0] r_data,
  output logic              r_empty,
  output logic [CNT_W-1:0]  count,
  input  logic              err_clr,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0]    PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(AFULL_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic              write_en;
  logic              read_en;

  // Status comes only from registered pointers. The MSB of each pointer is a wrap bit.
  // Equal low bits with different wrap bits means the FIFO is full.
  assign r_empty = (wptr == rptr);
  assign w_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  // Pointer distance modulo 2*DEPTH is the occupancy. For power-of-two DEPTH,
  // PW == CNT_W, so the value fits exactly.
  assign count   = CNT_W'(wptr - rptr);
  assign w_afull = (count >= AF_LEVEL);

  assign write_en = w_push & ~w_full;
  assign read_en  = r_pop & ~r_empty;

  assign r_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (write_en) begin
        mem[wptr[AW-1:0]] <= w_data;
        wptr              <= wptr + PTR_ONE;
      end
      if (read_en) begin
        rptr <= rptr + PTR_ONE;
      end
      // If an error occurs in the same cycle as err_clr, the flag stays set.
      ovf_err <= (ovf_err & ~err_clr) | (w_push & w_full);
      udf_err <= (udf_err & ~err_clr) | (r_pop & r_empty);
    end
  end

endmodule

// File: tb/tb_axi_sync_fifo.sv
module tb_axi_sync_fifo;

  logic       clk;
  logic       rst_n;
  logic       w_push;
  logic [7:0] w_data;
  logic       w_full;
  logic       w_afull;
  logic       r_pop;
  logic [7:0] r_data;
  logic       r_empty;
  logic [2:0] count;
  logic       err_clr;
  logic       ovf_err;
  logic       udf_err;

  int n_cmp = 0;
  int n_err = 0;

  axi_sync_fifo #(
    .DATA_W(8),
    .DEPTH(4),
    .AFULL_THRESH(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .w_push(w_push),
    .w_data(w_data),
    .w_full(w_full),
    .w_afull(w_afull),
    .r_pop(r_pop),
    .r_data(r_data),
    .r_empty(r_empty),
    .count(count),
    .err_clr(err_clr),
    .ovf_err(ovf_err),
    .udf_err(udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [7:0] d);
    w_push = 1'b1;
    w_data = d;
    step();
    w_push = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, 32'(r_data), 32'(exp));
    r_pop = 1'b1;
    step();
    r_pop = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    w_push  = 1'b0;
    w_data  = 8'h00;
    r_pop   = 1'b0;
    err_clr = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // 1. Reset state
    chk("rst_empty", 32'(r_empty), 32'd1);
    chk("rst_full",  32'(w_full),  32'd0);
    chk("rst_afull", 32'(w_afull), 32'd0);
    chk("rst_count", 32'(count),   32'd0);
    chk("rst_rdata", 32'(r_data),  32'h00);
    chk("rst_ovf",   32'(ovf_err), 32'd0);
    chk("rst_udf",   32'(udf_err), 32'd0);

    // 2. Fill with 0x11..0x44, then drain in order
    for (int i = 0; i < 4; i++) begin
      w_push = 1'b1;
      w_data = 8'((i + 1) * 8'h11);
      step();
      chk("fill_count", 32'(count),   32'(i + 1));
      chk("fill_head",  32'(r_data),  32'h11);
      chk("fill_empty", 32'(r_empty), 32'd0);
      chk("fill_afull", 32'(w_afull), 32'((i + 1) >= 3));
      chk("fill_full",  32'(w_full),  32'(i == 3));
    end
    w_push = 1'b0;
    pop_chk("drain0", 8'h11);
    pop_chk("drain1", 8'h22);
    pop_chk("drain2", 8'h33);
    pop_chk("drain3", 8'h44);
    chk("drain_empty", 32'(r_empty), 32'd1);
    chk("drain_count", 32'(count),   32'd0);
    chk("drain_ovf",   32'(ovf_err), 32'd0);
    chk("drain_udf",   32'(udf_err), 32'd0);

    // 3. Push while full, with a simultaneous pop
    push1(8'h11);
    push1(8'h22);
    push1(8'h33);
    push1(8'h44);
    w_push = 1'b1;
    w_data = 8'h55;
    r_pop  = 1'b1;
    #1;
    chk("full_nocomb", 32'(w_full), 32'd1);
    step();
    w_push = 1'b0;
    r_pop  = 1'b0;
    chk("ovf_count", 32'(count),   32'd3);
    chk("ovf_flag",  32'(ovf_err), 32'd1);
    chk("ovf_full",  32'(w_full),  32'd0);
    pop_chk("ovf_rd0", 8'h22);
    pop_chk("ovf_rd1", 8'h33);
    pop_chk("ovf_rd2", 8'h44);
    chk("ovf_empty", 32'(r_empty), 32'd1);
    chk("ovf_kept",  32'(ovf_err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovf_clr", 32'(ovf_err), 32'd0);

    // 4. Push while empty, with a simultaneous pop
    w_push = 1'b1;
    w_data = 8'hA5;
    r_pop  = 1'b1;
    #1;
    chk("empty_nocomb", 32'(r_empty), 32'd1);
    step();
    w_push = 1'b0;
    r_pop  = 1'b0;
    chk("udf_count", 32'(count),   32'd1);
    chk("udf_rdata", 32'(r_data),  32'hA5);
    chk("udf_flag",  32'(udf_err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("udf_clr",   32'(udf_err), 32'd0);
    chk("udf_keep",  32'(count),   32'd1);
    pop_chk("udf_rd", 8'hA5);

    // 5. Continuous push and pop at count 2, across pointer wrap
    push1(8'hE0);
    push1(8'hE1);
    for (int i = 0; i < 10; i++) begin
      chk("wrap_head", 32'(r_data), (i < 2) ? 32'(8'hE0 + i) : 32'(i - 2));
      w_push = 1'b1;
      w_data = 8'(i);
      r_pop  = 1'b1;
      step();
      chk("wrap_count", 32'(count), 32'd2);
    end
    w_push = 1'b0;
    r_pop  = 1'b0;
    pop_chk("wrap_tail0", 8'h08);
    pop_chk("wrap_tail1", 8'h09);
    chk("wrap_empty", 32'(r_empty), 32'd1);
    chk("wrap_errs",  32'({ovf_err, udf_err}), 32'd0);

    // 6. Reset while holding entries, with a push in the reset cycle
    push1(8'h61);
    push1(8'h62);
    push1(8'h63);
    chk("pre_rst_count", 32'(count), 32'd3);
    rst_n  = 1'b0;
    w_push = 1'b1;
    w_data = 8'h77;
    step();
    rst_n  = 1'b1;
    w_push = 1'b0;
    chk("mid_rst_count", 32'(count),   32'd0);
    chk("mid_rst_empty", 32'(r_empty), 32'd1);
    chk("mid_rst_rdata", 32'(r_data),  32'h00);
    step();
    chk("post_rst_count", 32'(count), 32'd0);
    push1(8'h3C);
    chk("post_rst_push", 32'(r_data), 32'h3C);
    chk("post_rst_cnt1", 32'(count),  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_sync_fifo.md
Name: axi_sync_fifo

Overview:
Parametrised single-clock FIFO for buffering AXI channel payloads (AR/AW/W/R/B) inside one clock domain. It is the next generation of the team's one-entry channel FIFO and generalises it to configurable width and power-of-two depth. It adds an occupancy count, an almost-full flag, and sticky overflow/underflow error flags. Read side is first-word-fall-through: r_data always shows the head entry.

Parameters:
DATA_W, 45, payload width in bits (≥1)
DEPTH, 4, number of entries; power of two, ≥2
AFULL_THRESH, DEPTH-1, occupancy at or above which w_afull asserts (1..DEPTH)
CNT_W, $clog2(DEPTH+1), derived width of count; not to be overridden

Ports:
clk  input  1  sole clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
w_push  input  1  write request
w_data  input  DATA_W  write payload
w_full  output  1  FIFO holds DEPTH entries
w_afull  output  1  count ≥ AFULL_THRESH
r_pop  input  1  read request; consumes head entry
r_data  output  DATA_W  head entry (FWFT)
r_empty  output  1  FIFO holds 0 entries
count  output  CNT_W  current occupancy, 0..DEPTH
err_clr  input  1  clears sticky error flags
ovf_err  output  1  sticky: push attempted while full
udf_err  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst_n=0 at a clock edge): write pointer = 0, read pointer = 0, count = 0, all memory entries = 0, ovf_err = 0, udf_err = 0.
- Outputs after reset: r_empty=1, w_full=0, w_afull=0, r_data=0.
- Pointers are log2(DEPTH)+1 bits. The extra MSB is a wrap bit.
  - empty = (wptr == rptr)
  - full = (low bits equal, MSBs differ)
  - Pointer increments wrap naturally modulo 2*DEPTH.
- w_full, r_empty, w_afull and count are pure functions of registered state. They are never combinationally dependent on w_push or r_pop.
- write_en = w_push & ~w_full. On write_en, mem[wptr low bits] <= w_data and wptr increments.
- read_en = r_pop & ~r_empty. On read_en, rptr increments.
- r_data = mem[rptr low bits], combinational from registered state. When empty, r_data shows stale memory content and carries no meaning.
- Latency:
  - Data pushed at edge N is visible on r_data, with r_empty=0, in the cycle after edge N (one-cycle fall-through).
  - A pop at edge N exposes the next entry after edge N.
- count update per edge:
  - +1 on write_en only
  - −1 on read_en only
  - unchanged on both or neither
- Simultaneous push and pop:
  - Not full and not empty: both occur and count is unchanged.
  - Full: pop occurs, push is rejected (w_full gates it) and flags ovf_err. Count goes DEPTH→DEPTH-1.
  - Empty: push occurs, pop is rejected and flags udf_err. Count goes 0→1.
- Errors:
  - ovf_err <= 1 on w_push & w_full.
  - udf_err <= 1 on r_pop & r_empty.
  - err_clr=1 clears both flags.
  - If a new error occurs in the same cycle as err_clr, set wins for that flag.
  - Rejected operations never modify memory, pointers or count.
- Reset mid-operation: any stored entries are discarded. State returns to the reset values at that edge, and pending w_push/r_pop in the reset cycle are ignored.
- No combinational path exists from w_push to r_empty, or from r_pop to w_full.

Test Plan:
Common configuration for all scenarios: DATA_W=8, DEPTH=4, AFULL_THRESH=3.
1. Reset then idle → r_empty=1, w_full=0, w_afull=0, count=0, r_data=0x00, ovf_err=0, udf_err=0.
2. Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles →
   - r_data=0x11 one cycle after the first push.
   - count steps 1,2,3,4.
   - w_afull rises when count=3; w_full=1 when count=4.
   - Four pops then return 0x11, 0x22, 0x33, 0x44 in order, and r_empty=1 after the last.
3. Fill to 4 entries, then push 0x55 with r_pop=1 in the same cycle →
   - Head 0x11 is consumed and 0x55 is dropped.
   - count=3, ovf_err=1.
   - Remaining reads are 0x22, 0x33, 0x44.
4. Empty FIFO, push 0xA5 with r_pop=1 in the same cycle → count=1, r_data=0xA5, udf_err=1. Then pulse err_clr → udf_err=0.
5. Wrap-around: run 10 cycles of continuous push+pop at steady count=2 with data 0x00..0x09 → output order is preserved across pointer wrap, and count stays 2 throughout.
6. With 3 entries stored, assert rst_n=0 for one edge while w_push=1 → count=0, r_empty=1, r_data=0x00, and no entry is written.
